match_ctrl: RTL and testbench
=============================

// Module: match_ctrl
// PURPOSE
//  Match sequencer for the ball-and-paddle game. Runs serve / rally / point /
//  game-over phases, gates the ball datapath (enable + reset), keeps both
//  5-bit scores and declares the winner. Sits between the ball/collision logic
//  (miss pulses in) and the score display and ball engine (controls out).
// PARAMETERS
//  WIN_SCORE    11    points needed to win (1..31)
//  SERVE_DELAY  50e6  cycles ball is held at centre before a rally starts (>=1)
//  POINT_HOLD   25e6  cycles the new score is shown before the next serve (>=1)
//  TMR_W        26    timer width; must hold max(SERVE_DELAY, POINT_HOLD)
// PORTS
//  clk         in   1  system clock
//  rst_n       in   1  asynchronous reset, active low
//  start       in   1  level; begin match (IDLE) or rematch (GAME_OVER)
//  miss_left   in   1  1-cycle pulse: ball passed left paddle (point to P2)
//  miss_right  in   1  1-cycle pulse: ball passed right paddle (point to P1)
//  score1      out  5  player-1 (left) score
//  score2      out  5  player-2 (right) score
//  ball_en     out  1  ball motion enable; high only in PLAY
//  ball_rst    out  1  hold ball at centre; high in IDLE, SERVE, POINT, GAME_OVER
//  serve_dir   out  1  0 = serve toward P1 (left), 1 = toward P2 (right)
//  game_over   out  1  high in GAME_OVER
//  winner      out  1  0 = P1, 1 = P2; valid while game_over=1, else 0
//  state       out  3  IDLE=0 SERVE=1 PLAY=2 POINT=3 GAME_OVER=4
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE, scores 0, timer 0, serve_dir=0,
//    winner=0, ball_en=0, ball_rst=1, game_over=0. All outputs are registered
//    or pure decodes of registered state.
//  - IDLE: start=1 -> SERVE next edge; scores cleared to 0, timer loaded.
//  - SERVE: timer counts SERVE_DELAY cycles (SERVE_DELAY edges in SERVE),
//    then -> PLAY. ball_en rises on the first PLAY cycle.
//  - PLAY: miss_left -> score2+1, serve_dir=0 (loser serves toward self);
//    miss_right -> score1+1, serve_dir=1. Score and state (-> POINT) update on
//    the same edge the pulse is sampled, i.e. 1-cycle latency.
//  - Simultaneous miss_left & miss_right in PLAY: no score change, serve_dir
//    unchanged, -> POINT (re-serve).
//  - Misses outside PLAY are ignored; start is ignored outside IDLE/GAME_OVER.
//  - POINT: hold POINT_HOLD cycles; then if a score has reached the win
//    condition -> GAME_OVER (winner latched), else -> SERVE.
//  - Win condition (base): score >= WIN_SCORE. Scores saturate at 31.
//  - GAME_OVER: scores frozen; start=1 -> SERVE, scores cleared, serve_dir
//    set to the loser's side, winner/game_over cleared on that edge.
//  - start held high across GAME_OVER entry: rematch on the first GAME_OVER
//    cycle (no edge detection; level-sensitive).
//  - Reset mid-rally or mid-timer returns to IDLE immediately; no partial
//    score retained.
//  - Illegal state encodings (5..7) -> IDLE on the next edge.
// CONFIGURATION
//  WIN_BY_TWO_EN defined: win requires score >= WIN_SCORE AND lead >= 2. If
//    either score hits 31 without a 2-point lead, the higher score wins
//    (tie at 31 impossible; saturation prevents it only after a point, so the
//    point that would tie at 31 awards the win to the scorer).
//  WIN_BY_TWO_EN undefined: first to WIN_SCORE wins, lead ignored.
// TESTING  (WIN_SCORE=3, SERVE_DELAY=4, POINT_HOLD=2)
//  - Reset, start pulse -> state 0->1, ball_rst=1 for 4 SERVE cycles, then
//    state=2, ball_en=1.
//  - PLAY, miss_right pulse -> next cycle score1=1, state=3, serve_dir=1,
//    ball_en=0; after 2 cycles state=1.
//  - P1 scores 3 straight (base build) -> GAME_OVER, winner=0, game_over=1,
//    score1=3 score2=0; further misses leave scores unchanged.
//  - WIN_BY_TWO_EN: reach 3-2 -> SERVE not GAME_OVER; 4-2 -> GAME_OVER winner=0.
//  - miss_left & miss_right same cycle in PLAY -> scores unchanged, POINT->SERVE.
//  - rst_n low during PLAY at 2-1 -> async IDLE, scores 0, ball_rst=1;
//    start during PLAY and misses during SERVE have no effect.

Source files
------------

// File: rtl/match_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : match_ctrl
//  Purpose  : Ball-and-paddle match sequencer: serve/rally/point/game-over
//             phases, ball gating, score keeping and winner declaration.
//             Optional macro WIN_BY_TWO_EN requires a two-point winning lead.
//  Revision : 1.0  initial release
// ============================================================================
module match_ctrl #(
    parameter int WIN_SCORE   = 11,
    parameter int SERVE_DELAY = 50_000_000,
    parameter int POINT_HOLD  = 25_000_000,
    parameter int TMR_W       = 26
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       miss_left,
    input  logic       miss_right,
    output logic [4:0] score1,
    output logic [4:0] score2,
    output logic       ball_en,
    output logic       ball_rst,
    output logic       serve_dir,
    output logic       game_over,
    output logic       winner,
    output logic [2:0] state
);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_SERVE     = 3'd1;
    localparam logic [2:0] c_PLAY      = 3'd2;
    localparam logic [2:0] c_POINT     = 3'd3;
    localparam logic [2:0] c_GAME_OVER = 3'd4;

    // Timers count down to zero, so a load of N-1 gives N cycles in the phase
    localparam logic [TMR_W-1:0] c_serve_load = TMR_W'(SERVE_DELAY - 1);
    localparam logic [TMR_W-1:0] c_point_load = TMR_W'(POINT_HOLD - 1);
    localparam logic [4:0]       c_win_score  = 5'(WIN_SCORE);
    localparam logic [4:0]       c_score_max  = 5'd31;

    logic [2:0]       r_state;
    logic [4:0]       r_score1;
    logic [4:0]       r_score2;
    logic [TMR_W-1:0] r_timer;
    logic             r_serve_dir;
    logic             r_winner;

    logic w_timer_done;
    logic w_p1_wins;
    logic w_p2_wins;

    assign w_timer_done = (r_timer == '0);

`ifdef WIN_BY_TWO_EN
    logic [5:0] w_s1_ext;
    logic [5:0] w_s2_ext;
    assign w_s1_ext = {1'b0, r_score1};
    assign w_s2_ext = {1'b0, r_score2};
    // A score pinned at 31 cannot grow its lead, so the higher score takes it
    assign w_p1_wins = ((r_score1 >= c_win_score) && (w_s1_ext >= w_s2_ext + 6'd2)) ||
                       ((r_score1 == c_score_max) && (r_score1 > r_score2));
    assign w_p2_wins = ((r_score2 >= c_win_score) && (w_s2_ext >= w_s1_ext + 6'd2)) ||
                       ((r_score2 == c_score_max) && (r_score2 > r_score1));
`else
    assign w_p1_wins = (r_score1 >= c_win_score);
    assign w_p2_wins = (r_score2 >= c_win_score);
`endif

    function automatic logic [4:0] sat_inc(input logic [4:0] s);
        return (s == c_score_max) ? s : s + 5'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_score1    <= '0;
            r_score2    <= '0;
            r_timer     <= '0;
            r_serve_dir <= 1'b0;
            r_winner    <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_state  <= c_SERVE;
                        r_score1 <= '0;
                        r_score2 <= '0;
                        r_timer  <= c_serve_load;
                    end
                end
                c_SERVE: begin
                    if (w_timer_done) r_state <= c_PLAY;
                    else              r_timer <= r_timer - 1'b1;
                end
                c_PLAY: begin
                    if (miss_left || miss_right) begin
                        r_state <= c_POINT;
                        r_timer <= c_point_load;
                    end
                    // A double miss is a re-serve: no score, direction kept
                    if (miss_left && !miss_right) begin
                        r_score2    <= sat_inc(r_score2);
                        r_serve_dir <= 1'b0;
                    end else if (miss_right && !miss_left) begin
                        r_score1    <= sat_inc(r_score1);
                        r_serve_dir <= 1'b1;
                    end
                end
                c_POINT: begin
                    if (!w_timer_done) begin
                        r_timer <= r_timer - 1'b1;
                    end else if (w_p1_wins || w_p2_wins) begin
                        r_state  <= c_GAME_OVER;
                        r_winner <= !w_p1_wins;
                    end else begin
                        r_state <= c_SERVE;
                        r_timer <= c_serve_load;
                    end
                end
                c_GAME_OVER: begin
                    if (start) begin
                        r_state     <= c_SERVE;
                        r_score1    <= '0;
                        r_score2    <= '0;
                        r_timer     <= c_serve_load;
                        r_serve_dir <= !r_winner;
                        r_winner    <= 1'b0;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign score1    = r_score1;
    assign score2    = r_score2;
    assign state     = r_state;
    assign serve_dir = r_serve_dir;
    assign ball_en   = (r_state == c_PLAY);
    assign ball_rst  = (r_state != c_PLAY);
    assign game_over = (r_state == c_GAME_OVER);
    assign winner    = r_winner && (r_state == c_GAME_OVER);

endmodule
`default_nettype wire

// File: tb/tb_match_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_match_ctrl
//  Purpose  : Directed table-driven bench for match_ctrl (WIN_SCORE=3,
//             SERVE_DELAY=4, POINT_HOLD=2); WIN_BY_TWO_EN selects extra case.
//  Revision : 1.0  initial release
// ============================================================================
module tb_match_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       miss_left;
    logic       miss_right;
    logic [4:0] score1;
    logic [4:0] score2;
    logic       ball_en;
    logic       ball_rst;
    logic       serve_dir;
    logic       game_over;
    logic       winner;
    logic [2:0] state;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        st;
        logic        ml;
        logic        mr;
        logic [17:0] exp;
    } vec_t;

    vec_t tbl[$];

    match_ctrl #(
        .WIN_SCORE   (3),
        .SERVE_DELAY (4),
        .POINT_HOLD  (2),
        .TMR_W       (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .miss_left  (miss_left),
        .miss_right (miss_right),
        .score1     (score1),
        .score2     (score2),
        .ball_en    (ball_en),
        .ball_rst   (ball_rst),
        .serve_dir  (serve_dir),
        .game_over  (game_over),
        .winner     (winner),
        .state      (state)
    );

    always #5 clk = ~clk;

    // Expected output word; enable/reset/game_over follow directly from state
    function automatic logic [17:0] mk(input logic [2:0] s, input int a, input int b,
                                       input logic sd, input logic w);
        return {s, 5'(a), 5'(b), (s == 3'd2), (s != 3'd2), sd, (s == 3'd4), w};
    endfunction

    function automatic logic [17:0] act();
        return {state, score1, score2, ball_en, ball_rst, serve_dir, game_over, winner};
    endfunction

    function automatic string fmt(input logic [17:0] v);
        return $sformatf("st=%0d s1=%0d s2=%0d en=%b brst=%b dir=%b go=%b win=%b",
                         v[17:15], v[14:10], v[9:5], v[4], v[3], v[2], v[1], v[0]);
    endfunction

    task automatic check(input string name, input logic [17:0] got, input logic [17:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %s, expected %s", name, fmt(got), fmt(exp));
        end
    endtask

    task automatic add(input logic st, input logic ml, input logic mr, input logic [2:0] s,
                       input int a, input int b, input logic sd, input logic w);
        vec_t v;
        v.st = st; v.ml = ml; v.mr = mr;
        v.exp = mk(s, a, b, sd, w);
        tbl.push_back(v);
    endtask

    task automatic cyc(input logic st, input logic ml, input logic mr);
        start = st; miss_left = ml; miss_right = mr;
        @(posedge clk);
        #1;
        start = 1'b0; miss_left = 1'b0; miss_right = 1'b0;
    endtask

    task automatic serve_wait();
        for (int k = 0; k < 4; k++) cyc(0, 0, 0);
    endtask

    // From PLAY: one miss, two POINT cycles, four SERVE cycles, back in PLAY
    task automatic play_point(input logic ml, input logic mr);
        cyc(0, ml, mr);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        serve_wait();
    endtask

    initial begin
        clk = 1'b0; rst_n = 1'b0;
        start = 1'b0; miss_left = 1'b0; miss_right = 1'b0;

        // start -> SERVE for four cycles -> PLAY
        add(1,0,0, 1, 0,0, 0,0);
        for (int k = 0; k < 3; k++) add(0,0,0, 1, 0,0, 0,0);
        add(0,0,0, 2, 0,0, 0,0);
        // point to P1, two POINT cycles, misses/start ignored in SERVE
        add(0,0,1, 3, 1,0, 1,0);
        add(0,0,0, 3, 1,0, 1,0);
        add(0,0,0, 1, 1,0, 1,0);
        add(0,1,0, 1, 1,0, 1,0);
        add(0,0,1, 1, 1,0, 1,0);
        add(1,0,0, 1, 1,0, 1,0);
        add(0,0,0, 2, 1,0, 1,0);
        add(1,0,0, 2, 1,0, 1,0);
        // point to P2
        add(0,1,0, 3, 1,1, 0,0);
        add(0,0,0, 3, 1,1, 0,0);
        for (int k = 0; k < 4; k++) add(0,0,0, 1, 1,1, 0,0);
        add(0,0,0, 2, 1,1, 0,0);
        // simultaneous misses: re-serve with no score change
        add(0,1,1, 3, 1,1, 0,0);
        add(0,0,0, 3, 1,1, 0,0);
        for (int k = 0; k < 4; k++) add(0,0,0, 1, 1,1, 0,0);
        add(0,0,0, 2, 1,1, 0,0);
        add(0,0,1, 3, 2,1, 1,0);
        add(0,0,0, 3, 2,1, 1,0);
        for (int k = 0; k < 4; k++) add(0,0,0, 1, 2,1, 1,0);
        add(0,0,0, 2, 2,1, 1,0);
        // P1 reaches 3 (lead of 2 too) -> GAME_OVER, scores frozen
        add(0,0,1, 3, 3,1, 1,0);
        add(0,0,0, 3, 3,1, 1,0);
        add(0,0,0, 4, 3,1, 1,0);
        add(0,1,0, 4, 3,1, 1,0);
        add(0,0,1, 4, 3,1, 1,0);
        // rematch: scores cleared, loser (P2) side serves
        add(1,0,0, 1, 0,0, 1,0);

        #12;
        check("reset_state", act(), mk(0, 0, 0, 0, 0));
        @(posedge clk);
        #1 rst_n = 1'b1;

        foreach (tbl[i]) begin
            start = tbl[i].st; miss_left = tbl[i].ml; miss_right = tbl[i].mr;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), act(), tbl[i].exp);
        end

        // Asynchronous reset during PLAY at 2-1
        start = 1'b0; miss_left = 1'b0; miss_right = 1'b0;
        serve_wait();
        play_point(0, 1);
        play_point(0, 1);
        play_point(1, 0);
        check("play_at_2_1", act(), mk(2, 2, 1, 0, 0));
        #1 rst_n = 1'b0;
        #1;
        check("async_reset", act(), mk(0, 0, 0, 0, 0));
        @(posedge clk);
        #1 rst_n = 1'b1;

        // start held high across GAME_OVER entry -> immediate rematch
        cyc(1, 0, 0);
        serve_wait();
        check("play_entry", act(), mk(2, 0, 0, 0, 0));
        play_point(0, 1);
        play_point(0, 1);
        cyc(0, 0, 1);
        cyc(1, 0, 0);
        check("start_in_point", act(), mk(3, 3, 0, 1, 0));
        cyc(1, 0, 0);
        check("gameover_p1", act(), mk(4, 3, 0, 1, 0));
        cyc(1, 0, 0);
        check("held_rematch", act(), mk(1, 0, 0, 1, 0));
        serve_wait();
        check("rematch_play", act(), mk(2, 0, 0, 1, 0));

`ifdef WIN_BY_TWO_EN
        play_point(0, 1);
        play_point(0, 1);
        play_point(1, 0);
        play_point(1, 0);
        check("tie_2_2", act(), mk(2, 2, 2, 0, 0));
        cyc(0, 0, 1);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        check("no_win_3_2", act(), mk(1, 3, 2, 1, 0));
        serve_wait();
        cyc(0, 0, 1);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        check("win_4_2", act(), mk(4, 4, 2, 1, 0));
`else
        play_point(1, 0);
        play_point(1, 0);
        cyc(0, 1, 0);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        check("gameover_p2", act(), mk(4, 0, 3, 0, 1));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
